// File: rtl/sample_period_meter.sv
// Measures ce strobe spacing in clk cycles and ns, with lock and loss-of-strobe status.
// Define SAMPLE_PERIOD_METER_AVG_EN to report the mean of 2^AVG_LOG2 periods instead of each one.
module sample_period_meter #(
  parameter int unsigned CLK_PERIOD_NS  = 10,
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000,
  parameter int unsigned AVG_LOG2       = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_in_i,
  output logic [31:0] period_cycles_o,
  output logic [31:0] period_ns_o,
  output logic        period_valid_o,
  output logic        locked_o,
  output logic        timeout_o
);

  if (TIMEOUT_CYCLES < 2 || AVG_LOG2 > 8) begin : g_bad_params
    $error("sample_period_meter: TIMEOUT_CYCLES or AVG_LOG2 out of range");
  end

  typedef enum logic [0:0] {StIdle, StMeasure} state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        raw_vld_q, raw_vld_d;
  logic [31:0] raw_q, raw_d;
  logic        vld_q, vld_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ns_q, ns_d;
  logic        locked_q, locked_d;
  logic        timeout_q, timeout_d;
  logic        meas_evt;
  logic        expire;
  logic [63:0] prod;

`ifdef SAMPLE_PERIOD_METER_AVG_EN
  localparam int unsigned AccW    = 32 + AVG_LOG2;
  localparam logic [8:0]  SmpLast = 9'((1 << AVG_LOG2) - 1);

  logic [AccW-1:0] acc_q, acc_d, acc_sum;
  logic [8:0]      smp_q, smp_d;
`endif

  // Interval counter and phase tracking
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    meas_evt  = 1'b0;
    expire    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ce_in_i) begin
          cnt_d     = 32'd1;
          state_d   = StMeasure;
          timeout_d = 1'b0;
        end
      end
      StMeasure: begin
        if (ce_in_i) begin
          cnt_d    = 32'd1;
          meas_evt = 1'b1;
        end else if (cnt_q == TIMEOUT_CYCLES) begin
          state_d   = StIdle;
          timeout_d = 1'b1;
          expire    = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Stage 1: raw (or window-averaged) period
`ifdef SAMPLE_PERIOD_METER_AVG_EN
  always_comb begin
    raw_vld_d = 1'b0;
    raw_d     = raw_q;
    acc_d     = acc_q;
    smp_d     = smp_q;
    acc_sum   = acc_q + AccW'(cnt_q);
    if (expire) begin
      acc_d = '0;
      smp_d = '0;
    end else if (meas_evt) begin
      if (smp_q == SmpLast) begin
        raw_vld_d = 1'b1;
        raw_d     = 32'(acc_sum >> AVG_LOG2);
        acc_d     = '0;
        smp_d     = '0;
      end else begin
        acc_d = acc_sum;
        smp_d = smp_q + 9'd1;
      end
    end
  end
`else
  always_comb begin
    raw_vld_d = meas_evt;
    raw_d     = meas_evt ? cnt_q : raw_q;
  end
`endif

  // Stage 2: ns conversion with saturation, output registers and lock
  always_comb begin
    prod     = 64'(raw_q) * 64'(CLK_PERIOD_NS);
    vld_d    = raw_vld_q && !expire;
    pc_d     = pc_q;
    ns_d     = ns_q;
    locked_d = locked_q;
    if (vld_d) begin
      pc_d     = raw_q;
      ns_d     = (|prod[63:32]) ? 32'hFFFF_FFFF : prod[31:0];
      locked_d = 1'b1;
    end
    if (expire) begin
      locked_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      raw_vld_q <= 1'b0;
      raw_q     <= '0;
      vld_q     <= 1'b0;
      pc_q      <= '0;
      ns_q      <= '0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
`ifdef SAMPLE_PERIOD_METER_AVG_EN
      acc_q     <= '0;
      smp_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      raw_vld_q <= raw_vld_d;
      raw_q     <= raw_d;
      vld_q     <= vld_d;
      pc_q      <= pc_d;
      ns_q      <= ns_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
`ifdef SAMPLE_PERIOD_METER_AVG_EN
      acc_q     <= acc_d;
      smp_q     <= smp_d;
`endif
    end
  end

  assign period_cycles_o = pc_q;
  assign period_ns_o     = ns_q;
  assign period_valid_o  = vld_q;
  assign locked_o        = locked_q;
  assign timeout_o       = timeout_q;

endmodule

// File: tb/tb_sample_period_meter.sv
// Scoreboard bench: two instances (normal and saturating ns multiplier) share one strobe stream.
module tb_sample_period_meter;
  localparam int unsigned TO    = 100;
  localparam int unsigned NS_A  = 10;
  localparam int unsigned NS_B  = 32'h8000_0000;
  localparam int unsigned AVG   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce_in = 1'b0;
  logic [31:0] pc_a, ns_a, pc_b, ns_b;
  logic        vld_a, lck_a, tmo_a, vld_b, lck_b, tmo_b;

  sample_period_meter #(.CLK_PERIOD_NS(NS_A), .TIMEOUT_CYCLES(TO), .AVG_LOG2(AVG)) dut_a (
    .clk(clk), .rst(rst), .ce_in_i(ce_in), .period_cycles_o(pc_a), .period_ns_o(ns_a),
    .period_valid_o(vld_a), .locked_o(lck_a), .timeout_o(tmo_a)
  );

  sample_period_meter #(.CLK_PERIOD_NS(NS_B), .TIMEOUT_CYCLES(TO), .AVG_LOG2(AVG)) dut_b (
    .clk(clk), .rst(rst), .ce_in_i(ce_in), .period_cycles_o(pc_b), .period_ns_o(ns_b),
    .period_valid_o(vld_b), .locked_o(lck_b), .timeout_o(tmo_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned emit;
    logic [31:0] pc;
    logic [31:0] ns_a;
    logic [31:0] ns_b;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_fail = 0;
  int unsigned cyc = 0;
  bit          have_ev = 1'b0;
  int unsigned last_ev = 0;
`ifdef SAMPLE_PERIOD_METER_AVG_EN
  int unsigned win[$];
`endif

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] to_ns(input logic [31:0] c, input logic [31:0] k);
    logic [63:0] p;
    p = 64'(c) * 64'(k);
    return (p > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : p[31:0];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic push_period(input int unsigned t, input logic [31:0] c);
    exp_t e;
    e.emit = t + 2;
    e.pc   = c;
    e.ns_a = to_ns(c, NS_A);
    e.ns_b = to_ns(c, NS_B);
    sb.push_back(e);
  endtask

  // Reference: period is the spacing of consecutive events unless it exceeds the timeout
  task automatic model_event(input int unsigned t);
    int unsigned gap;
    if (have_ev && (t - last_ev) <= TO) begin
      gap = t - last_ev;
`ifdef SAMPLE_PERIOD_METER_AVG_EN
      win.push_back(gap);
      if (win.size() == (1 << AVG)) begin
        longint unsigned sum = 0;
        foreach (win[i]) sum += win[i];
        push_period(t, 32'(sum >> AVG));
        win.delete();
      end
`else
      push_period(t, gap);
`endif
    end else begin
`ifdef SAMPLE_PERIOD_METER_AVG_EN
      win.delete();
`endif
    end
    have_ev = 1'b1;
    last_ev = t;
  endtask

  task automatic drive(input logic ce);
    @(negedge clk);
    rst   = 1'b1;
    ce_in = ce;
    if (ce) model_event(cyc);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst     = 1'b0;
    ce_in   = 1'b0;
    have_ev = 1'b0;
    sb.delete();
`ifdef SAMPLE_PERIOD_METER_AVG_EN
    win.delete();
`endif
    repeat (n - 1) @(negedge clk);
  endtask

  // Monitor
  logic        locked_exp = 1'b0;
  logic [31:0] hold_pc = '0, hold_a = '0, hold_b = '0;

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      locked_exp = 1'b0;
      hold_pc = '0; hold_a = '0; hold_b = '0;
      chk("rst_valid", 32'({vld_a, vld_b}), 32'd0);
      chk("rst_locked", 32'({lck_a, lck_b}), 32'd0);
      chk("rst_timeout", 32'({tmo_a, tmo_b}), 32'd0);
      chk("rst_pc", pc_a | pc_b, 32'd0);
      chk("rst_ns", ns_a | ns_b, 32'd0);
    end else begin
      logic texp, vexp;
      exp_t e;
      texp = have_ev && ((cyc - 1 - last_ev) >= TO);
      if (texp) locked_exp = 1'b0;
      vexp = (sb.size() > 0) && (sb[0].emit == cyc);
      chk("valid_a", 32'(vld_a), 32'(vexp));
      chk("valid_b", 32'(vld_b), 32'(vexp));
      if (vexp) begin
        e = sb.pop_front();
        hold_pc = e.pc; hold_a = e.ns_a; hold_b = e.ns_b;
        locked_exp = 1'b1;
      end
      chk("period_cycles_a", pc_a, hold_pc);
      chk("period_cycles_b", pc_b, hold_pc);
      chk("period_ns_a", ns_a, hold_a);
      chk("period_ns_b_sat", ns_b, hold_b);
      chk("timeout_a", 32'(tmo_a), 32'(texp));
      chk("timeout_b", 32'(tmo_b), 32'(texp));
      chk("locked_a", 32'(lck_a), 32'(locked_exp));
      chk("locked_b", 32'(lck_b), 32'(locked_exp));
    end
  end

  initial begin
    int gaps[4];
    gaps = '{4, 4, 5, 6};
    repeat (3) @(negedge clk);
    // Periodic strobe every 5 cycles
    repeat (10) begin
      drive(1'b1);
      repeat (4) drive(1'b0);
    end
    // Continuous strobe
    repeat (20) drive(1'b1);
    // Loss of strobe, recovery, period 7, gap exactly at limit, gap one past limit
    repeat (150) drive(1'b0);
    drive(1'b1);
    repeat (6) drive(1'b0);
    drive(1'b1);
    repeat (99) drive(1'b0);
    drive(1'b1);
    repeat (100) drive(1'b0);
    drive(1'b1);
    repeat (3) drive(1'b0);
    drive(1'b1);
    // Averaging window pattern after a fresh timeout
    repeat (120) drive(1'b0);
    drive(1'b1);
    foreach (gaps[i]) begin
      repeat (gaps[i] - 1) drive(1'b0);
      drive(1'b1);
    end
    repeat (10) drive(1'b0);
    // Random strobe with occasional near-timeout gaps
    repeat (1500) begin
      if ($urandom_range(0, 99) < 3) begin
        repeat ($urandom_range(95, 105)) drive(1'b0);
        drive(1'b1);
      end else begin
        drive($urandom_range(0, 3) == 0);
      end
    end
    // Reset on the cycle after an event
    drive(1'b1);
    repeat (3) drive(1'b0);
    drive(1'b1);
    do_reset(2);
    repeat (5) drive(1'b0);
    // Continuous strobe straight from reset release
    do_reset(3);
    repeat (20) drive(1'b1);
    repeat (10) drive(1'b0);
    @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected periods, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sample_period_meter.md
# sample_period_meter

Measures the spacing of an incoming sample-strobe stream and reports it both as a clock-cycle count and as nanoseconds, the inverse of the sample clock-enable generation path. It sits on the capture side of the sampling datapath: it observes a `ce`-style strobe, either looped back from our own generator or coming from an external source. Software reads back the effective sample period, lock status and a loss-of-strobe timeout.

## Interface
- `CLK_PERIOD_NS`, 10: `clk` period in ns, the multiplier for the ns conversion; 32-bit unsigned.
- `TIMEOUT_CYCLES`, 100_000_000: cycles without a strobe before declaring loss; legal range 2..2^32-1.
- `AVG_LOG2`, 2: log2 of the averaging window; legal range 0..8; used only when averaging is compiled in.

Ports:
- `clk`  in  1: clock.
- `rst`  in  1: reset, synchronous, active-low.
- `ce_in`  in  1: sample strobe; every cycle it is high counts as one event. A continuously high `ce_in` is an event every cycle.
- `period_cycles`  out  32: last measured (or averaged) period in `clk` cycles.
- `period_ns`  out  32: `period_cycles * CLK_PERIOD_NS`, saturated to 0xFFFF_FFFF.
- `period_valid`  out  1: one-cycle pulse when both period outputs update.
- `locked`  out  1: high once at least one valid period has been reported since reset or timeout.
- `timeout`  out  1: high from loss-of-strobe until the next `ce_in` event.

## Operation
- Reset (`rst`=0): all outputs are 0. State goes to IDLE, the counter, accumulator and pipeline are cleared, and any in-flight `period_valid` is dropped.
- FSM states: IDLE and MEASURE.
  - In IDLE, a `ce_in` event sets `cnt`<=1, moves to MEASURE and clears `timeout`. No measurement is produced, because the first event only establishes phase.
  - In MEASURE, on a `ce_in` event, `cnt` is captured as the raw period and `cnt`<=1. With no event, `cnt`<=`cnt`+1.
  - In MEASURE, when `cnt`==`TIMEOUT_CYCLES` and `ce_in`=0: go to IDLE, set `timeout`<=1 and `locked`<=0, clear the accumulator and sample counter, and drop the pipeline. `period_cycles` and `period_ns` hold their last values.
  - When an event arrives in the same cycle that `cnt`==`TIMEOUT_CYCLES`, the event wins. The raw period is `TIMEOUT_CYCLES` and no timeout is raised.
- Raw period: the number of `clk` cycles between consecutive events, minimum 1.
- Conversion:
  - Compute the 32x32 to 64-bit product `cycles*CLK_PERIOD_NS`.
  - If bits [63:32] are nonzero, `period_ns`=0xFFFF_FFFF; otherwise `period_ns` is the low 32 bits.
  - `period_cycles` carries the unconverted cycle count.
- `locked` is set on the first `period_valid` and cleared only by reset or timeout.

## Timing
- Event at cycle T in MEASURE: raw period registered at T+1, product registered and `period_valid`=1 with new outputs at T+2. Latency is 2 cycles.
- Back-to-back events every cycle give `period_valid` high every cycle, with the pipeline fully streaming.
- Timeout: for the last event at T, `timeout` rises at T+`TIMEOUT_CYCLES`+1.
- After a timeout, `timeout` clears on the cycle after the next event. The first valid output follows the second event, at that event's cycle plus 2.
- Reset asserted at any cycle: outputs are 0 on the next cycle, and no `period_valid` is issued from events before reset.

## Configuration
- `SAMPLE_PERIOD_METER_AVG_EN` defined:
  - Raw periods accumulate in a (32+`AVG_LOG2`)-bit accumulator.
  - After 2^`AVG_LOG2` raw periods, the average is `sum >> AVG_LOG2` (floor). It is converted, and one `period_valid` fires 2 cycles after the event completing the window.
  - The accumulator then clears.
  - A timeout discards a partial window.
- `SAMPLE_PERIOD_METER_AVG_EN` undefined: no accumulator is built; every raw period is reported individually. `AVG_LOG2` is ignored.

## Test plan
- Periodic strobe, `CLK_PERIOD_NS`=10: `ce_in` every 5 cycles gives `period_cycles`=5 and `period_ns`=50, with `period_valid` 2 cycles after each event except the first. `locked` rises with the first valid.
- Continuous strobe: `ce_in` held high gives `period_cycles`=1, `period_ns`=10 and `period_valid` every cycle from the third cycle after release of reset.
- Timeout, `TIMEOUT_CYCLES`=100: last event at T gives `timeout`=1 and `locked`=0 at T+101, with outputs held.
  - Next event gives no valid and clears `timeout`.
  - The following event 7 cycles later gives `period_cycles`=7.
  - An event exactly at `cnt`==100 gives `period_cycles`=100 and no timeout.
- Saturation, `CLK_PERIOD_NS`=32'h8000_0000: strobe every 2 cycles gives `period_cycles`=2 and `period_ns`=0xFFFF_FFFF.
- Reset mid-pipeline: `rst`=0 on the cycle after an event gives no `period_valid`, all outputs 0, and `locked`=0.
- With `SAMPLE_PERIOD_METER_AVG_EN` defined and `AVG_LOG2`=2: periods 4,4,5,6 give a single `period_valid` with `period_cycles`=4 and `period_ns`=40.
